aes_128_key_sched_ctrl: RTL and testbench

Iterative, clocked AES-128 key-expansion controller. It accepts a cipher key over a valid/ready handshake and generates the 11 round keys (rk0..rk10), one per cycle, into an internal round-key store. It serves any round key to the encryption/decryption round datapath through an indexed, registered read port. It replaces the fully combinational key schedule wherever area matters more than a 10-cycle setup latency.

---
 rtl/aes_128_key_sched_ctrl.sv | 160 ++++++++++++++++
 tb/tb_aes_128_key_sched_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/aes_128_key_sched_ctrl.sv
// aes_128_key_sched_ctrl: iterative AES-128 key expansion.
// A key is taken on a valid/ready handshake. Over the next 10 cycles the
// controller writes rk1..rk10 into an 11-entry round-key store. Any entry can
// be read through a registered port.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   key_in        128-bit cipher key, FIPS-197 byte order (MSB = byte 0)
//   key_valid     key_in holds a key to expand
//   key_ready     a key can be accepted (IDLE or DONE)
//   busy          expansion in progress
//   keys_valid    rk0..rk10 are complete for the last accepted key
//   rk_idx        round-key read index, 0..10
//   rk_out        registered store[rk_idx] (0 when the index is out of range)
//   rk_idx_err    registered flag, set when the sampled rk_idx > 10

// Byte substitution, built from the GF(2^8) inverse plus the affine map.
// This avoids a literal 256-entry table.
module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    // x^254 is the inverse of x (0 maps to 0). 254 = 2+4+...+128.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] s;
        logic [7:0] acc;
        s   = a;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            s   = gf_mul(s, s);
            acc = gf_mul(acc, s);
        end
        return acc;
    endfunction

    logic [7:0] b;

    always_comb begin
        b    = gf_inv(din);
        dout = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
endmodule

module aes_128_key_sched_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic         busy,
    output logic         keys_valid,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_out,
    output logic         rk_idx_err
);
    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t       state_q, state_d;
    logic [3:0]   round_q;
    logic [127:0] store [0:10];

    logic [127:0] prev;
    logic [127:0] next_key;
    logic [127:0] rd_data;
    logic [31:0]  rot, sub, t;
    logic [31:0]  w4, w5, w6, w7;
    logic [7:0]   rcon;
    logic         accept;

    assign key_ready = (state_q != EXPAND);
    assign busy      = (state_q == EXPAND);
    assign accept    = key_valid && key_ready;

    always_comb begin
        case (round_q)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // Explicit muxes keep 4-bit indices from running past the 11-entry store.
    always_comb begin
        prev    = '0;
        rd_data = '0;
        for (int i = 0; i < 11; i++) begin
            if (round_q == 4'(i + 1)) prev    = store[i];
            if (rk_idx == 4'(i))      rd_data = store[i];
        end
    end

    assign rot = {prev[23:0], prev[31:24]};  // RotWord(w3)

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (.din(rot[g*8 +: 8]), .dout(sub[g*8 +: 8]));
    end

    assign t        = sub ^ {rcon, 24'h0};
    assign w4       = prev[127:96] ^ t;
    assign w5       = w4 ^ prev[95:64];
    assign w6       = w5 ^ prev[63:32];
    assign w7       = w6 ^ prev[31:0];
    assign next_key = {w4, w5, w6, w7};

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (key_valid) state_d = EXPAND;
            EXPAND:     if (round_q == 4'd10) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            round_q    <= 4'd0;
            keys_valid <= 1'b0;
            rk_out     <= '0;
            rk_idx_err <= 1'b0;
            for (int i = 0; i < 11; i++) store[i] <= '0;
        end else begin
            state_q    <= state_d;
            // The read samples the store before this edge's write, so there is no bypass.
            rk_out     <= rd_data;
            rk_idx_err <= (rk_idx > 4'd10);
            if (accept) begin
                store[0]   <= key_in;
                round_q    <= 4'd1;
                keys_valid <= 1'b0;
            end else if (state_q == EXPAND) begin
                for (int i = 1; i < 11; i++)
                    if (round_q == 4'(i)) store[i] <= next_key;
                if (round_q == 4'd10) keys_valid <= 1'b1;
                else                  round_q    <= round_q + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_aes_128_key_sched_ctrl.sv
// Directed bench for aes_128_key_sched_ctrl. Expected round keys come from
// FIPS-197 Appendix A.1 and the standard all-zero-key expansion.
module tb_aes_128_key_sched_ctrl;
    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         busy;
    logic         keys_valid;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;
    logic         rk_idx_err;

    int n_checks = 0;
    int n_pass   = 0;
    int busy_cnt;

    localparam logic [127:0] FK0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FK2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] FK3  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    localparam logic [127:0] FK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    aes_128_key_sched_ctrl dut (
        .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid),
        .key_ready(key_ready), .busy(busy), .keys_valid(keys_valid),
        .rk_idx(rk_idx), .rk_out(rk_out), .rk_idx_err(rk_idx_err)
    );

    always #5 clk = ~clk;

    // One rising edge, then settle 1ns so inputs change and outputs are sampled away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic read_chk(input string tag, input logic [3:0] idx, input logic [127:0] exp,
                            input logic exp_err);
        rk_idx = idx;
        step();
        chk(tag, rk_out, exp);
        chk({tag, "_err"}, 128'(rk_idx_err), 128'(exp_err));
    endtask

    task automatic accept_key(input logic [127:0] k);
        key_in    = k;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; key_in = '0; key_valid = 1'b0; rk_idx = 4'd0;
        step(); step();
        rst = 1'b0;
        chk("rst_ready", 128'(key_ready), 128'(1'b1));
        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk("rst_kv", 128'(keys_valid), 128'(1'b0));
        chk("rst_rk_out", rk_out, '0);
        chk("rst_err", 128'(rk_idx_err), 128'(1'b0));

        // FIPS key accepted at edge N. Probe the read-during-write of entry 3.
        accept_key(FK0);
        chk("acc_ready", 128'(key_ready), 128'(1'b0));
        rk_idx   = 4'd3;
        busy_cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            if (busy) busy_cnt++;
            step();                                   // edge N+k
            if (k == 3) chk("rd3_old", rk_out, '0);   // pre-write value
            if (k == 4) chk("rd3_new", rk_out, FK3);
            if (k == 9) chk("kv_lo_n9", 128'(keys_valid), 128'(1'b0));
        end
        if (busy) busy_cnt++;
        chk("busy_cycles", 128'(busy_cnt), 128'(10));
        chk("kv_n10", 128'(keys_valid), 128'(1'b1));
        chk("ready_n10", 128'(key_ready), 128'(1'b1));
        read_chk("f_rk0", 4'd0, FK0, 1'b0);
        read_chk("f_rk1", 4'd1, FK1, 1'b0);
        read_chk("f_rk2", 4'd2, FK2, 1'b0);
        read_chk("f_rk10", 4'd10, FK10, 1'b0);

        // Out-of-range indices
        read_chk("idx11", 4'd11, '0, 1'b1);
        read_chk("idx15", 4'd15, '0, 1'b1);
        read_chk("idx10", 4'd10, FK10, 1'b0);

        // All-zero key
        accept_key('0);
        for (int k = 1; k <= 10; k++) step();
        chk("z_kv", 128'(keys_valid), 128'(1'b1));
        read_chk("z_rk1", 4'd1, ZK1, 1'b0);
        read_chk("z_rk10", 4'd10, ZK10, 1'b0);

        // Key_valid is held with a second key during expansion.
        key_in = '0; key_valid = 1'b1;
        step();                                        // accept at N
        key_in = FK0;
        for (int k = 1; k <= 9; k++) begin
            step();
            chk("hold_no_acc", 128'(key_ready), 128'(1'b0));
        end
        step();                                        // N+10
        chk("hold_kv_n10", 128'(keys_valid), 128'(1'b1));
        step();                                        // N+11: second accept
        key_valid = 1'b0;
        chk("hold_kv_drop", 128'(keys_valid), 128'(1'b0));
        chk("hold_busy", 128'(busy), 128'(1'b1));
        for (int k = 12; k <= 20; k++) step();
        chk("hold_kv_n20", 128'(keys_valid), 128'(1'b0));
        step();                                        // N+21
        chk("hold_kv_n21", 128'(keys_valid), 128'(1'b1));
        read_chk("hold_rk10", 4'd10, FK10, 1'b0);
        read_chk("hold_rk1", 4'd1, FK1, 1'b0);

        // Reset during expansion
        accept_key(FK0);
        for (int k = 1; k <= 4; k++) step();
        rst = 1'b1;
        step();                                        // N+5
        rst = 1'b0;
        chk("mrst_ready", 128'(key_ready), 128'(1'b1));
        chk("mrst_busy", 128'(busy), 128'(1'b0));
        chk("mrst_kv", 128'(keys_valid), 128'(1'b0));
        for (int i = 0; i <= 10; i++) read_chk("mrst_clr", 4'(i), '0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
